reservation_station: RTL and testbench

//  Tomasulo-style operand-waiting buffer, directly downstream of the rename map table.

---
 rtl/reservation_station.sv | 201 ++++++++++++++++++++
 tb/tb_reservation_station.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched instructions until both source
// operands are available (from dispatch or the CDB), then issues the
// lowest-index ready entry to a single functional unit.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 4
`endif

// One station slot: valid bit, identity, payload and two operand sources.
module rs_entry #(
    parameter int TAG_W     = `ROB_TAG_LEN,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    input  logic                 alloc,
    input  logic                 release_entry,
    input  logic [TAG_W-1:0]     dispatch_rob_tag,
    input  logic [PAYLOAD_W-1:0] dispatch_payload,
    input  logic [TAG_W-1:0]     rs1_tag,
    input  logic [TAG_W-1:0]     rs2_tag,
    input  logic                 rs1_ready,
    input  logic                 rs2_ready,
    input  logic [DATA_W-1:0]    rs1_value,
    input  logic [DATA_W-1:0]    rs2_value,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [DATA_W-1:0]    cdb_value,
    output logic                 valid,
    output logic                 ready,
    output logic [TAG_W-1:0]     rob_tag,
    output logic [PAYLOAD_W-1:0] payload,
    output logic [DATA_W-1:0]    opa,
    output logic [DATA_W-1:0]    opb
);
    logic             s1_rdy, s2_rdy;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic             cdb_live;
    logic             fwd1, fwd2, wake1, wake2;
    logic             src1_now, src2_now;

    // Tag 0 is the "register file" name and must never match a broadcast.
    assign cdb_live = cdb_valid && (cdb_tag != '0);

    // Operand resolution at dispatch: map-table ready wins, else same-cycle CDB forward.
    assign src1_now = (rs1_tag == '0) || rs1_ready;
    assign src2_now = (rs2_tag == '0) || rs2_ready;
    assign fwd1     = !src1_now && cdb_live && (cdb_tag == rs1_tag);
    assign fwd2     = !src2_now && cdb_live && (cdb_tag == rs2_tag);

    // Wakeup of a resident, still-waiting source.
    assign wake1 = valid && !s1_rdy && cdb_live && (cdb_tag == s1_tag);
    assign wake2 = valid && !s2_rdy && cdb_live && (cdb_tag == s2_tag);

    assign ready = valid && s1_rdy && s2_rdy;

    // Entry state: reset clears everything, squash only drops the valid bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid   <= 1'b0;
            rob_tag <= '0;
            payload <= '0;
            s1_rdy  <= 1'b0;
            s2_rdy  <= 1'b0;
            s1_tag  <= '0;
            s2_tag  <= '0;
            opa     <= '0;
            opb     <= '0;
        end else if (squash) begin
            valid <= 1'b0;
        end else if (release_entry) begin
            valid <= 1'b0;
        end else if (alloc) begin
            valid   <= 1'b1;
            rob_tag <= dispatch_rob_tag;
            payload <= dispatch_payload;
            s1_tag  <= rs1_tag;
            s2_tag  <= rs2_tag;
            s1_rdy  <= src1_now || fwd1;
            s2_rdy  <= src2_now || fwd2;
            opa     <= src1_now ? rs1_value : (fwd1 ? cdb_value : '0);
            opb     <= src2_now ? rs2_value : (fwd2 ? cdb_value : '0);
        end else begin
            if (wake1) begin
                s1_rdy <= 1'b1;
                opa    <= cdb_value;
            end
            if (wake2) begin
                s2_rdy <= 1'b1;
                opb    <= cdb_value;
            end
        end
    end
endmodule

module reservation_station #(
    parameter int RS_SIZE   = 4,
    parameter int TAG_W     = `ROB_TAG_LEN,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    input  logic                 dispatch_valid,
    input  logic [TAG_W-1:0]     dispatch_rob_tag,
    input  logic [PAYLOAD_W-1:0] dispatch_payload,
    input  logic [TAG_W-1:0]     rs1_tag,
    input  logic [TAG_W-1:0]     rs2_tag,
    input  logic                 rs1_ready,
    input  logic                 rs2_ready,
    input  logic [DATA_W-1:0]    rs1_value,
    input  logic [DATA_W-1:0]    rs2_value,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [DATA_W-1:0]    cdb_value,
    output logic                 full,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [TAG_W-1:0]     issue_rob_tag,
    output logic [DATA_W-1:0]    issue_opa,
    output logic [DATA_W-1:0]    issue_opb,
    output logic [PAYLOAD_W-1:0] issue_payload
);
    logic [RS_SIZE-1:0]                entry_valid, entry_ready;
    logic [RS_SIZE-1:0]                alloc_oh, sel_oh, release_oh;
    logic [RS_SIZE-1:0][TAG_W-1:0]     entry_tag;
    logic [RS_SIZE-1:0][PAYLOAD_W-1:0] entry_payload;
    logic [RS_SIZE-1:0][DATA_W-1:0]    entry_opa, entry_opb;
    logic                              alloc_found, sel_found;

    // Full looks only at registered valid bits, so a same-cycle issue never frees room.
    assign full        = &entry_valid;
    assign issue_valid = |entry_ready;
    assign release_oh  = issue_ready ? sel_oh : '0;

    // Lowest free slot gets the dispatch; nothing is allocated while full or squashing.
    always_comb begin
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!entry_valid[i] && !alloc_found) begin
                alloc_oh[i] = dispatch_valid && !squash;
                alloc_found = 1'b1;
            end
        end
    end

    // Lowest ready slot drives the issue port; outputs are zero when nothing is ready.
    always_comb begin
        sel_oh        = '0;
        sel_found     = 1'b0;
        issue_rob_tag = '0;
        issue_opa     = '0;
        issue_opb     = '0;
        issue_payload = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (entry_ready[i] && !sel_found) begin
                sel_oh[i]     = 1'b1;
                sel_found     = 1'b1;
                issue_rob_tag = entry_tag[i];
                issue_opa     = entry_opa[i];
                issue_opb     = entry_opb[i];
                issue_payload = entry_payload[i];
            end
        end
    end

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_entry
        rs_entry #(
            .TAG_W    (TAG_W),
            .DATA_W   (DATA_W),
            .PAYLOAD_W(PAYLOAD_W)
        ) u_entry (
            .clock           (clock),
            .reset           (reset),
            .squash          (squash),
            .alloc           (alloc_oh[g]),
            .release_entry   (release_oh[g]),
            .dispatch_rob_tag(dispatch_rob_tag),
            .dispatch_payload(dispatch_payload),
            .rs1_tag         (rs1_tag),
            .rs2_tag         (rs2_tag),
            .rs1_ready       (rs1_ready),
            .rs2_ready       (rs2_ready),
            .rs1_value       (rs1_value),
            .rs2_value       (rs2_value),
            .cdb_valid       (cdb_valid),
            .cdb_tag         (cdb_tag),
            .cdb_value       (cdb_value),
            .valid           (entry_valid[g]),
            .ready           (entry_ready[g]),
            .rob_tag         (entry_tag[g]),
            .payload         (entry_payload[g]),
            .opa             (entry_opa[g]),
            .opb             (entry_opb[g])
        );
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: a slot-array model predicts every
// output each cycle, and hand-computed literals pin the key scenarios.
module tb_reservation_station;
    localparam int N  = 4;
    localparam int TW = 4;
    localparam int DW = 32;
    localparam int PW = 32;

    logic          clock = 1'b0;
    logic          reset, squash, dispatch_valid;
    logic [TW-1:0] dispatch_rob_tag, rs1_tag, rs2_tag, cdb_tag, issue_rob_tag;
    logic [PW-1:0] dispatch_payload, issue_payload;
    logic          rs1_ready, rs2_ready, cdb_valid, full, issue_valid, issue_ready;
    logic [DW-1:0] rs1_value, rs2_value, cdb_value, issue_opa, issue_opb;

    int compared = 0;
    int mismatched = 0;

    reservation_station #(.RS_SIZE(N), .TAG_W(TW), .DATA_W(DW), .PAYLOAD_W(PW)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .dispatch_valid(dispatch_valid), .dispatch_rob_tag(dispatch_rob_tag),
        .dispatch_payload(dispatch_payload),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .full(full), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rob_tag(issue_rob_tag), .issue_opa(issue_opa), .issue_opb(issue_opb),
        .issue_payload(issue_payload)
    );

    always #5 clock = ~clock;

    // ---------------- model: slot array with plain rules ----------------
    bit            m_v[N];
    bit            m_r1[N], m_r2[N];
    int            m_t1[N], m_t2[N], m_tag[N];
    logic [DW-1:0] m_a[N], m_b[N];
    logic [PW-1:0] m_p[N];

    function automatic int first_ready();
        for (int i = 0; i < N; i++)
            if (m_v[i] && m_r1[i] && m_r2[i]) return i;
        return -1;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < N; i++)
            if (!m_v[i]) return i;
        return -1;
    endfunction

    always @(posedge clock) begin
        int sel, fr;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_t1[i] = 0; m_t2[i] = 0;
                m_tag[i] = 0; m_a[i] = '0; m_b[i] = '0; m_p[i] = '0;
            end
        end else if (squash) begin
            for (int i = 0; i < N; i++) m_v[i] = 0;
        end else begin
            sel = first_ready();
            fr  = first_free();
            for (int i = 0; i < N; i++) begin
                if (m_v[i] && cdb_valid && cdb_tag != 0) begin
                    if (!m_r1[i] && m_t1[i] == int'(cdb_tag)) begin m_r1[i] = 1; m_a[i] = cdb_value; end
                    if (!m_r2[i] && m_t2[i] == int'(cdb_tag)) begin m_r2[i] = 1; m_b[i] = cdb_value; end
                end
            end
            if (sel >= 0 && issue_ready) m_v[sel] = 0;
            if (dispatch_valid && fr >= 0) begin
                m_v[fr] = 1; m_tag[fr] = int'(dispatch_rob_tag); m_p[fr] = dispatch_payload;
                m_t1[fr] = int'(rs1_tag); m_t2[fr] = int'(rs2_tag);
                if (rs1_tag == 0 || rs1_ready) begin m_r1[fr] = 1; m_a[fr] = rs1_value; end
                else if (cdb_valid && cdb_tag == rs1_tag) begin m_r1[fr] = 1; m_a[fr] = cdb_value; end
                else begin m_r1[fr] = 0; m_a[fr] = '0; end
                if (rs2_tag == 0 || rs2_ready) begin m_r2[fr] = 1; m_b[fr] = rs2_value; end
                else if (cdb_valid && cdb_tag == rs2_tag) begin m_r2[fr] = 1; m_b[fr] = cdb_value; end
                else begin m_r2[fr] = 0; m_b[fr] = '0; end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clock) begin
        int s;
        bit f;
        s = first_ready();
        f = 1;
        for (int i = 0; i < N; i++) f = f && m_v[i];
        check("model_full", 64'(full), 64'(f));
        check("model_issue_valid", 64'(issue_valid), 64'(s >= 0));
        check("model_rob_tag", 64'(issue_rob_tag), s >= 0 ? 64'(m_tag[s]) : 64'd0);
        check("model_opa", 64'(issue_opa), s >= 0 ? 64'(m_a[s]) : 64'd0);
        check("model_opb", 64'(issue_opb), s >= 0 ? 64'(m_b[s]) : 64'd0);
        check("model_payload", 64'(issue_payload), s >= 0 ? 64'(m_p[s]) : 64'd0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        squash = 0; dispatch_valid = 0; dispatch_rob_tag = '0; dispatch_payload = '0;
        rs1_tag = '0; rs2_tag = '0; rs1_ready = 0; rs2_ready = 0;
        rs1_value = '0; rs2_value = '0; cdb_valid = 0; cdb_tag = '0; cdb_value = '0;
    endtask

    task automatic disp(input int tag, input int t1, input bit r1, input int v1,
                        input int t2, input bit r2, input int v2);
        dispatch_valid = 1; dispatch_rob_tag = TW'(tag); dispatch_payload = PW'(32'h100 + tag);
        rs1_tag = TW'(t1); rs1_ready = r1; rs1_value = DW'(v1);
        rs2_tag = TW'(t2); rs2_ready = r2; rs2_value = DW'(v2);
    endtask

    initial begin
        idle();
        reset = 1; issue_ready = 0;
        step(); step();
        check("reset_full", 64'(full), 64'd0);
        check("reset_issue_valid", 64'(issue_valid), 64'd0);
        check("reset_opa", 64'(issue_opa), 64'd0);
        reset = 0;

        // 1: both operands from the register file
        issue_ready = 1;
        disp(3, 0, 0, 5, 0, 0, 7);
        step(); idle();
        check("t1_valid", 64'(issue_valid), 64'd1);
        check("t1_tag", 64'(issue_rob_tag), 64'd3);
        check("t1_opa", 64'(issue_opa), 64'd5);
        check("t1_opb", 64'(issue_opb), 64'd7);
        check("t1_payload", 64'(issue_payload), 64'h103);
        step();
        check("t1_drained", 64'(issue_valid), 64'd0);

        // 2: wait on tag 1, broadcast two cycles later
        disp(2, 1, 0, 0, 0, 0, 3);
        step(); idle();
        check("t2_wait0", 64'(issue_valid), 64'd0);
        step();
        check("t2_wait1", 64'(issue_valid), 64'd0);
        cdb_valid = 1; cdb_tag = 1; cdb_value = 32'hAA;
        step(); idle();
        check("t2_woken", 64'(issue_valid), 64'd1);
        check("t2_opa", 64'(issue_opa), 64'hAA);
        step();
        check("t2_drained", 64'(issue_valid), 64'd0);

        // 3: same-cycle CDB forward at dispatch
        disp(5, 0, 0, 1, 4, 0, 0);
        cdb_valid = 1; cdb_tag = 4; cdb_value = 9;
        step(); idle();
        check("t3_valid", 64'(issue_valid), 64'd1);
        check("t3_opb", 64'(issue_opb), 64'd9);
        step();

        // 4: fill, drop, wake entry 2, refill slot 2
        issue_ready = 0;
        for (int i = 0; i < N; i++) begin
            disp(6 + i, 10 + i, 0, 0, 0, 0, 0);
            step();
        end
        idle();
        check("t4_full", 64'(full), 64'd1);
        disp(14, 0, 0, 1, 0, 0, 2);
        step(); idle();
        check("t4_dropped", 64'(issue_valid), 64'd0);
        cdb_valid = 1; cdb_tag = 12; cdb_value = 32'h55;
        step(); idle();
        check("t4_woke_tag", 64'(issue_rob_tag), 64'd8);
        issue_ready = 1;
        step();
        check("t4_not_full", 64'(full), 64'd0);
        disp(13, 0, 0, 4, 0, 0, 6);
        step(); idle();
        check("t4_refill_full", 64'(full), 64'd1);
        check("t4_refill_tag", 64'(issue_rob_tag), 64'd13);
        squash = 1; issue_ready = 0;
        step(); idle();
        check("t4_squashed", 64'(full), 64'd0);

        // 5: hold under backpressure, then drain in index order
        disp(1, 0, 0, 32'h11, 0, 0, 32'h22); step();
        disp(2, 14, 0, 0, 0, 0, 0); step();
        disp(3, 15, 0, 0, 0, 0, 0); step();
        disp(4, 0, 0, 32'h33, 0, 0, 32'h44); step();
        idle();
        for (int c = 0; c < 3; c++) begin
            check("t5_hold_tag", 64'(issue_rob_tag), 64'd1);
            check("t5_hold_opa", 64'(issue_opa), 64'h11);
            step();
        end
        issue_ready = 1;
        step();
        check("t5_next_tag", 64'(issue_rob_tag), 64'd4);
        check("t5_next_opb", 64'(issue_opb), 64'h44);
        step();
        check("t5_empty_ready", 64'(issue_valid), 64'd0);
        issue_ready = 0;

        // 6: squash beats a simultaneous dispatch (entries 1,2 still resident)
        disp(7, 0, 0, 1, 0, 0, 1); step();
        disp(9, 0, 0, 2, 0, 0, 2);
        squash = 1;
        step(); idle();
        check("t6_full", 64'(full), 64'd0);
        check("t6_issue_valid", 64'(issue_valid), 64'd0);
        disp(10, 0, 0, 3, 0, 0, 4);
        step(); idle();
        check("t6_fresh_tag", 64'(issue_rob_tag), 64'd10);

        // reset mid-operation
        reset = 1;
        step();
        reset = 0;
        check("reset_mid_valid", 64'(issue_valid), 64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
